can_fd_rx_frame_fsm: RTL and testbench
======================================

Name: can_fd_rx_frame_fsm

Overview:
- Receive-side frame sequencer for the CAN FD controller.
- Consumes destuffed, sampled bits one strobe at a time and walks the ISO 11898-1 field sequence for classic and FD frames, in both base and extended formats.
- Exposes the current field as a numbered state and the decoded header: ID, flags, DLC and byte count.
- Flags form violations, frame validity, overload and intermission SOF. Sits between the bit-timing/destuff logic and the RX buffer/CRC checker.

Parameters:
- MAX_DATA_BYTES, 64: largest payload accepted; 8 gives a classic-only receiver.
- EOF_BITS, 7: end-of-frame length.
- INTER_BITS, 3: intermission length.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- bit_valid  in  1  one-cycle strobe; a destuffed bit is present (FD fixed stuff bits already removed)
- rx_bit  in  1  sampled bit, 0 = dominant
- fd_enable  in  1  1 = FD frames accepted
- abort  in  1  synchronous return to BUS_IDLE (error frame handled elsewhere)
- state_o  out  5  current field code
- field_cnt_o  out  9  bit index inside the current field
- id_o  out  29  identifier; base ID in [28:18], extended in [28:0]
- ide_o, rtr_o, fdf_o, brs_o, esi_o  out  1 each  decoded flags
- dlc_o  out  4  DLC
- data_len_o  out  7  payload byte count
- frame_ok_o  out  1  pulse: frame valid
- form_err_o  out  1  pulse: form error
- overload_o  out  1  pulse: dominant in early intermission

Behaviour:
- Reset (rst_n=0, async): state BUS_IDLE. All outputs and counters are 0.
- Bit processing:
  - State updates only on clk edges where bit_valid=1; outputs are registered (1-cycle latency from strobe).
  - field_cnt clears on field entry and increments per bit.
  - A field of length L exits on the bit where field_cnt==L-1.
- State codes, in order: BUS_IDLE=0, ID_1, RTR_1, IDE, ID_2, RTR_2, R1, R0, R0_FD, BRS, ESI, DLC, DATA, CRC, CRC_LIM, ACK, ACK_LIM, EOF, INTER=18.
- Frame start: BUS_IDLE + dominant bit (SOF) goes to ID_1 (11 bits, shifted MSB-first into id_o[28:18]). At SOF, flags, dlc_o and data_len_o clear.
- RTR_1: 1 bit; holds RTR, SRR or RRS; any value accepted. Then IDE.
- IDE = 0 (base format): goes to R0. The R0 bit is FDF.
- IDE = 1 (extended format): ID_2 (18 bits into id_o[17:0]), then RTR_2, then R1. The R1 bit is FDF.
- FDF = 0 (classic):
  - Extended path goes R1 → R0 → DLC.
  - Base path goes R0 → DLC.
  - rtr_o = the RTR_1 bit (base) or RTR_2 bit (extended).
- FDF = 1:
  - With fd_enable=0: form_err, go to BUS_IDLE.
  - Otherwise: R0_FD (res) → BRS → ESI → DLC. rtr_o = 0.
- DLC (4 bits) decodes to data_len:
  - DLC 0–8 gives 0–8 bytes. Classic DLC >8 gives 8 bytes.
  - FD DLC 9–15 gives 12, 16, 20, 24, 32, 48, 64 bytes.
  - Classic RTR gives 0 bytes.
  - data_len > MAX_DATA_BYTES: form_err.
  - data_len = 0: skip DATA and go straight to CRC.
- DATA: 8·data_len bits.
- CRC length:
  - 15 bits classic.
  - FD: 21 bits if data_len ≤ 16, else 25 bits (stuff-count + parity included).
- CRC_LIM: must be 1, else form_err.
- ACK: any value.
- ACK_LIM: must be 1, else form_err.
- EOF:
  - Dominant in bits 0..EOF_BITS-2: form_err.
  - frame_ok pulses on bit EOF_BITS-2 (recessive).
  - The last EOF bit is ignored.
  - Then INTER.
- INTER:
  - Dominant in bits 0..INTER_BITS-2: overload pulse, go to BUS_IDLE.
  - Dominant on the last bit: treated as SOF, go to ID_1.
  - Otherwise, after INTER_BITS bits, go to BUS_IDLE.
- On form_err: single pulse, then BUS_IDLE. Decoded fields hold until the next SOF.
- abort:
  - Overrides bit_valid; goes to BUS_IDLE next edge with field_cnt=0 and no pulses.
  - abort and rst_n together: reset wins.
- Pulses are exactly one cycle wide. At most one of frame_ok, form_err and overload is asserted per cycle.

Test Plan:
- Classic base frame, ID 0x123, DLC 2, data 0xA5 0x5A, recessive delimiters → states 0→1→2→3→7→11→12→13(15 bits)→14…→18. id_o[28:18]=0x123; data_len_o=2; frame_ok on EOF bit 5.
- FD extended frame, ID 0x1ABCDEF0, BRS=1, DLC 15, fd_enable=1 → path ID_2→RTR_2→R1→R0_FD→BRS→ESI. data_len_o=64, DATA 512 bits, CRC 25 bits, frame_ok asserted.
- fd_enable=0, base frame with FDF=1 → form_err one cycle after the R0 bit, state 0.
- Dominant CRC_LIM in a classic DLC 0 frame → form_err, BUS_IDLE. Next SOF restarts cleanly.
- abort asserted at DATA bit 20 → BUS_IDLE next edge, field_cnt_o=0, no pulses. A subsequent frame decodes correctly.
- MAX_DATA_BYTES=8, FD DLC 9 → form_err at DLC end. Separately: dominant at INTER bit 2 → SOF into ID_1; dominant at INTER bit 0 → overload pulse.

Source files
------------

// File: rtl/can_fd_rx_frame_fsm.sv
// ---------------------------------------------------------------------------
// can_fd_rx_frame_fsm
//
// Receive-side frame sequencer for a CAN FD controller. Consumes destuffed,
// sampled bits (one per bit_valid strobe) and walks the ISO 11898-1 field
// sequence for classic and FD frames in base and extended format. It reports
// the current field and the bit index inside it. It also decodes the header
// fields (ID, flags, DLC, byte count) and flags form violations, frame
// validity and overload conditions.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   bit_valid         one-cycle strobe, a destuffed bit is on rx_bit
//   rx_bit            sampled bit, 0 = dominant
//   fd_enable         1 = FD frames are accepted
//   abort             synchronous return to BUS_IDLE, overrides bit_valid
//   state_o           current field code (BUS_IDLE=0 .. INTER=18)
//   field_cnt_o       bit index inside the current field
//   id_o              identifier; base ID in [28:18], extended ID in [28:0]
//   ide_o .. esi_o    decoded IDE / RTR / FDF / BRS / ESI flags
//   dlc_o, data_len_o DLC and the payload byte count it decodes to
//   frame_ok_o        one-cycle pulse, frame valid
//   form_err_o        one-cycle pulse, form error
//   overload_o        one-cycle pulse, dominant bit in early intermission
// ---------------------------------------------------------------------------
module can_fd_rx_frame_fsm #(
    parameter int MAX_DATA_BYTES = 64,
    parameter int EOF_BITS       = 7,
    parameter int INTER_BITS     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_valid,
    input  logic        rx_bit,
    input  logic        fd_enable,
    input  logic        abort,
    output logic [4:0]  state_o,
    output logic [8:0]  field_cnt_o,
    output logic [28:0] id_o,
    output logic        ide_o,
    output logic        rtr_o,
    output logic        fdf_o,
    output logic        brs_o,
    output logic        esi_o,
    output logic [3:0]  dlc_o,
    output logic [6:0]  data_len_o,
    output logic        frame_ok_o,
    output logic        form_err_o,
    output logic        overload_o
);

    localparam logic [4:0] ST_BUS_IDLE = 5'd0;
    localparam logic [4:0] ST_ID_1     = 5'd1;
    localparam logic [4:0] ST_RTR_1    = 5'd2;
    localparam logic [4:0] ST_IDE      = 5'd3;
    localparam logic [4:0] ST_ID_2     = 5'd4;
    localparam logic [4:0] ST_RTR_2    = 5'd5;
    localparam logic [4:0] ST_R1       = 5'd6;
    localparam logic [4:0] ST_R0       = 5'd7;
    localparam logic [4:0] ST_R0_FD    = 5'd8;
    localparam logic [4:0] ST_BRS      = 5'd9;
    localparam logic [4:0] ST_ESI      = 5'd10;
    localparam logic [4:0] ST_DLC      = 5'd11;
    localparam logic [4:0] ST_DATA     = 5'd12;
    localparam logic [4:0] ST_CRC      = 5'd13;
    localparam logic [4:0] ST_CRC_LIM  = 5'd14;
    localparam logic [4:0] ST_ACK      = 5'd15;
    localparam logic [4:0] ST_ACK_LIM  = 5'd16;
    localparam logic [4:0] ST_EOF      = 5'd17;
    localparam logic [4:0] ST_INTER    = 5'd18;

    localparam logic [9:0] EOF_LEN    = 10'(EOF_BITS);
    localparam logic [9:0] INTER_LEN  = 10'(INTER_BITS);
    localparam logic [8:0] EOF_OK_IDX = 9'(EOF_BITS - 2);
    localparam logic [8:0] INTER_LAST = 9'(INTER_BITS - 1);
    localparam logic [7:0] MAX_LEN    = 8'(MAX_DATA_BYTES);

    // DLC to payload byte count. Classic remote frames carry no data and
    // classic DLC values above 8 still mean 8 bytes.
    function automatic logic [6:0] dlc_to_len(input logic [3:0] dlc,
                                              input logic       fd,
                                              input logic       rtr);
        logic [6:0] len;
        len = 7'd0;
        if (!fd && rtr)          len = 7'd0;
        else if (dlc <= 4'd8)    len = {3'b000, dlc};
        else if (!fd)            len = 7'd8;
        else begin
            case (dlc)
                4'd9:    len = 7'd12;
                4'd10:   len = 7'd16;
                4'd11:   len = 7'd20;
                4'd12:   len = 7'd24;
                4'd13:   len = 7'd32;
                4'd14:   len = 7'd48;
                default: len = 7'd64;
            endcase
        end
        return len;
    endfunction

    logic [4:0] state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic       ok_d, ferr_d, ovl_d, sof_d;
    logic [9:0] field_len;
    logic       last_bit;
    logic [3:0] dlc_shift;
    logic [6:0] dec_len;
    logic [9:0] crc_len;

    assign dlc_shift = {dlc_o[2:0], rx_bit};
    assign dec_len   = dlc_to_len(dlc_shift, fdf_o, rtr_o);
    // FD CRC fields include the stuff count and its parity.
    assign crc_len   = !fdf_o ? 10'd15 : (data_len_o <= 7'd16 ? 10'd21 : 10'd25);

    // NOTE: every signal written in a combinational block gets a default at
    // the top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        field_len = 10'd1;
        case (state_q)
            ST_ID_1:  field_len = 10'd11;
            ST_ID_2:  field_len = 10'd18;
            ST_DLC:   field_len = 10'd4;
            ST_DATA:  field_len = {data_len_o, 3'b000};
            ST_CRC:   field_len = crc_len;
            ST_EOF:   field_len = EOF_LEN;
            ST_INTER: field_len = INTER_LEN;
            default:  field_len = 10'd1;
        endcase
    end

    assign last_bit = ({1'b0, cnt_q} == field_len - 10'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ok_d    = 1'b0;
        ferr_d  = 1'b0;
        ovl_d   = 1'b0;
        sof_d   = 1'b0;
        if (abort) begin
            state_d = ST_BUS_IDLE;
            cnt_d   = '0;
        end else if (bit_valid) begin
            cnt_d = cnt_q + 9'd1;
            case (state_q)
                ST_BUS_IDLE: begin
                    // The counter stays parked at 0 while the bus is idle.
                    cnt_d = '0;
                    if (!rx_bit) begin
                        state_d = ST_ID_1;
                        sof_d   = 1'b1;
                    end
                end
                ST_ID_1:  if (last_bit) begin state_d = ST_RTR_1; cnt_d = '0; end
                ST_RTR_1: begin state_d = ST_IDE; cnt_d = '0; end
                ST_IDE:   begin state_d = rx_bit ? ST_ID_2 : ST_R0; cnt_d = '0; end
                ST_ID_2:  if (last_bit) begin state_d = ST_RTR_2; cnt_d = '0; end
                ST_RTR_2: begin state_d = ST_R1; cnt_d = '0; end
                ST_R1, ST_R0: begin
                    cnt_d = '0;
                    // FDF lives in R1 for extended frames and in R0 for base
                    // frames; the extended-format R0 is a plain reserved bit.
                    if (state_q == ST_R0 && ide_o) begin
                        state_d = ST_DLC;
                    end else if (!rx_bit) begin
                        state_d = (state_q == ST_R1) ? ST_R0 : ST_DLC;
                    end else if (!fd_enable) begin
                        state_d = ST_BUS_IDLE;
                        ferr_d  = 1'b1;
                    end else begin
                        state_d = ST_R0_FD;
                    end
                end
                ST_R0_FD: begin state_d = ST_BRS; cnt_d = '0; end
                ST_BRS:   begin state_d = ST_ESI; cnt_d = '0; end
                ST_ESI:   begin state_d = ST_DLC; cnt_d = '0; end
                ST_DLC: if (last_bit) begin
                    cnt_d = '0;
                    if ({1'b0, dec_len} > MAX_LEN) begin
                        state_d = ST_BUS_IDLE;
                        ferr_d  = 1'b1;
                    end else begin
                        state_d = (dec_len == 7'd0) ? ST_CRC : ST_DATA;
                    end
                end
                ST_DATA: if (last_bit) begin state_d = ST_CRC; cnt_d = '0; end
                ST_CRC:  if (last_bit) begin state_d = ST_CRC_LIM; cnt_d = '0; end
                ST_CRC_LIM, ST_ACK_LIM: begin
                    cnt_d = '0;
                    if (!rx_bit) begin
                        state_d = ST_BUS_IDLE;
                        ferr_d  = 1'b1;
                    end else begin
                        state_d = (state_q == ST_CRC_LIM) ? ST_ACK : ST_EOF;
                    end
                end
                ST_ACK: begin state_d = ST_ACK_LIM; cnt_d = '0; end
                ST_EOF: begin
                    // The final EOF bit is not checked, so a dominant there
                    // neither fails the frame nor cancels frame_ok.
                    if (!rx_bit && cnt_q <= EOF_OK_IDX) begin
                        state_d = ST_BUS_IDLE;
                        cnt_d   = '0;
                        ferr_d  = 1'b1;
                    end else begin
                        ok_d = (cnt_q == EOF_OK_IDX);
                        if (last_bit) begin state_d = ST_INTER; cnt_d = '0; end
                    end
                end
                ST_INTER: begin
                    if (!rx_bit) begin
                        cnt_d = '0;
                        if (cnt_q == INTER_LAST) begin
                            state_d = ST_ID_1;
                            sof_d   = 1'b1;
                        end else begin
                            state_d = ST_BUS_IDLE;
                            ovl_d   = 1'b1;
                        end
                    end else if (last_bit) begin
                        state_d = ST_BUS_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_BUS_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: clocked state is written only with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BUS_IDLE;
            cnt_q      <= '0;
            frame_ok_o <= 1'b0;
            form_err_o <= 1'b0;
            overload_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_ok_o <= ok_d;
            form_err_o <= ferr_d;
            overload_o <= ovl_d;
        end
    end

    // Decoded header fields; they hold across errors until the next SOF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_o       <= '0;
            ide_o      <= 1'b0;
            rtr_o      <= 1'b0;
            fdf_o      <= 1'b0;
            brs_o      <= 1'b0;
            esi_o      <= 1'b0;
            dlc_o      <= '0;
            data_len_o <= '0;
        end else if (bit_valid && !abort) begin
            if (sof_d) begin
                ide_o      <= 1'b0;
                rtr_o      <= 1'b0;
                fdf_o      <= 1'b0;
                brs_o      <= 1'b0;
                esi_o      <= 1'b0;
                dlc_o      <= '0;
                data_len_o <= '0;
            end
            case (state_q)
                ST_ID_1:  id_o[28:18] <= {id_o[27:18], rx_bit};
                ST_ID_2:  id_o[17:0]  <= {id_o[16:0], rx_bit};
                // RTR_1 holds SRR in extended frames; RTR_2 overwrites it.
                ST_RTR_1, ST_RTR_2: rtr_o <= rx_bit;
                ST_IDE:   ide_o <= rx_bit;
                ST_R1, ST_R0: begin
                    if (state_q == ST_R1 || !ide_o) begin
                        fdf_o <= rx_bit;
                        // FD frames have no remote form; the bit was RRS.
                        if (rx_bit) rtr_o <= 1'b0;
                    end
                end
                ST_BRS:   brs_o <= rx_bit;
                ST_ESI:   esi_o <= rx_bit;
                ST_DLC: begin
                    dlc_o <= dlc_shift;
                    if (last_bit) data_len_o <= dec_len;
                end
                default: ;
            endcase
        end
    end

    assign state_o     = state_q;
    assign field_cnt_o = cnt_q;

endmodule

// File: tb/tb_can_fd_rx_frame_fsm.sv
// ---------------------------------------------------------------------------
// Testbench for can_fd_rx_frame_fsm. Frames are described at field level;
// the reference model expands a description into the bit stream plus the
// field code and bit index expected after every bit, the pulse expected on
// the terminating bit and the decoded header. Two instances are used: the
// default build and a classic-sized build (MAX_DATA_BYTES = 8).
// ---------------------------------------------------------------------------
module tb_can_fd_rx_frame_fsm;

    localparam int EOF_BITS   = 7;
    localparam int INTER_BITS = 3;

    // Field codes in specification order.
    localparam logic [4:0] S_IDLE = 5'd0,  S_ID1 = 5'd1,   S_RTR1 = 5'd2,  S_IDE = 5'd3;
    localparam logic [4:0] S_ID2  = 5'd4,  S_RTR2 = 5'd5,  S_R1 = 5'd6,    S_R0 = 5'd7;
    localparam logic [4:0] S_R0FD = 5'd8,  S_BRS = 5'd9,   S_ESI = 5'd10,  S_DLC = 5'd11;
    localparam logic [4:0] S_DATA = 5'd12, S_CRC = 5'd13,  S_CRCL = 5'd14, S_ACK = 5'd15;
    localparam logic [4:0] S_ACKL = 5'd16, S_EOF = 5'd17,  S_INTER = 5'd18;

    localparam int T_IDLE = 0, T_FERR = 1, T_OVL = 2, T_SOF = 3;

    typedef struct {
        bit        ext;
        bit [28:0] id;
        bit        rtr, fdf, brs, esi;
        bit [3:0]  dlc;
        bit        crc_lim, ack_lim;
        int        eof_dom;
        int        inter_dom;
        bit        fd_en;
        int        max_bytes;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic bit_valid = 1'b0, rx_bit = 1'b1, fd_enable = 1'b0, abort = 1'b0;
    bit   sel = 1'b0;

    logic [4:0]  st_a, st_b;
    logic [8:0]  cnt_a, cnt_b;
    logic [28:0] id_a, id_b;
    logic        ide_a, rtr_a, fdf_a, brs_a, esi_a, ok_a, fe_a, ov_a;
    logic        ide_b, rtr_b, fdf_b, brs_b, esi_b, ok_b, fe_b, ov_b;
    logic [3:0]  dlc_a, dlc_b;
    logic [6:0]  len_a, len_b;

    always #5 clk = ~clk;

    can_fd_rx_frame_fsm dut (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid && !sel), .rx_bit(rx_bit),
        .fd_enable(fd_enable), .abort(abort), .state_o(st_a), .field_cnt_o(cnt_a),
        .id_o(id_a), .ide_o(ide_a), .rtr_o(rtr_a), .fdf_o(fdf_a), .brs_o(brs_a),
        .esi_o(esi_a), .dlc_o(dlc_a), .data_len_o(len_a), .frame_ok_o(ok_a),
        .form_err_o(fe_a), .overload_o(ov_a)
    );

    can_fd_rx_frame_fsm #(.MAX_DATA_BYTES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid && sel), .rx_bit(rx_bit),
        .fd_enable(fd_enable), .abort(abort), .state_o(st_b), .field_cnt_o(cnt_b),
        .id_o(id_b), .ide_o(ide_b), .rtr_o(rtr_b), .fdf_o(fdf_b), .brs_o(brs_b),
        .esi_o(esi_b), .dlc_o(dlc_b), .data_len_o(len_b), .frame_ok_o(ok_b),
        .form_err_o(fe_b), .overload_o(ov_b)
    );

    // Outputs of the instance currently under test.
    logic [4:0]  o_st;
    logic [8:0]  o_cnt;
    logic [2:0]  o_pulse;
    logic [28:0] o_id;
    logic [4:0]  o_flags;
    logic [3:0]  o_dlc;
    logic [6:0]  o_len;
    assign o_st    = sel ? st_b  : st_a;
    assign o_cnt   = sel ? cnt_b : cnt_a;
    assign o_pulse = sel ? {ok_b, fe_b, ov_b} : {ok_a, fe_a, ov_a};
    assign o_id    = sel ? id_b  : id_a;
    assign o_flags = sel ? {ide_b, rtr_b, fdf_b, brs_b, esi_b} : {ide_a, rtr_a, fdf_a, brs_a, esi_a};
    assign o_dlc   = sel ? dlc_b : dlc_a;
    assign o_len   = sel ? len_b : len_a;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    bit         q_bit[$];
    logic [4:0] q_st[$];
    int         q_cnt[$];
    int         term, ok_idx, data_start, exp_len;
    bit         hdr_done;
    bit         sof_pending = 1'b0;

    function automatic int dlen(bit [3:0] d, bit fdf, bit rtr);
        if (!fdf && rtr) return 0;
        if (d <= 8)      return int'(d);
        if (!fdf)        return 8;
        case (d)
            4'd9:    return 12;
            4'd10:   return 16;
            4'd11:   return 20;
            4'd12:   return 24;
            4'd13:   return 32;
            4'd14:   return 48;
            default: return 64;
        endcase
    endfunction

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic push_one(input logic [4:0] st, input bit b, input int cnt);
        q_bit.push_back(b);
        q_st.push_back(st);
        q_cnt.push_back(cnt);
    endtask

    task automatic push_bits(input logic [4:0] st, input logic [31:0] val, input int n);
        for (int i = 0; i < n; i++) push_one(st, val[n-1-i], i);
    endtask

    task automatic push_rand(input logic [4:0] st, input int n);
        for (int i = 0; i < n; i++) push_one(st, rbit(), i);
    endtask

    // Expand a frame description into per-bit expectations.
    task automatic build(input frame_t f);
        int crc_len;
        q_bit.delete(); q_st.delete(); q_cnt.delete();
        term = T_IDLE; ok_idx = -1; data_start = -1; hdr_done = 1'b0;
        exp_len = dlen(f.dlc, f.fdf, f.rtr);
        if (!sof_pending) begin
            repeat ($urandom_range(0, 3)) push_one(S_IDLE, 1'b1, 0);
            push_one(S_IDLE, 1'b0, 0);
        end
        push_bits(S_ID1, {21'd0, f.id[28:18]}, 11);
        push_one(S_RTR1, f.ext ? rbit() : f.rtr, 0);
        push_one(S_IDE, f.ext, 0);
        if (f.ext) begin
            push_bits(S_ID2, {14'd0, f.id[17:0]}, 18);
            push_one(S_RTR2, f.fdf ? rbit() : f.rtr, 0);
            push_one(S_R1, f.fdf, 0);
            if (!f.fdf) push_one(S_R0, rbit(), 0);
        end else begin
            push_one(S_R0, f.fdf, 0);
        end
        if (f.fdf && !f.fd_en) begin term = T_FERR; return; end
        if (f.fdf) begin
            push_one(S_R0FD, rbit(), 0);
            push_one(S_BRS, f.brs, 0);
            push_one(S_ESI, f.esi, 0);
        end
        push_bits(S_DLC, {28'd0, f.dlc}, 4);
        hdr_done = 1'b1;
        if (exp_len > f.max_bytes) begin term = T_FERR; return; end
        if (exp_len > 0) begin
            data_start = q_bit.size();
            push_rand(S_DATA, 8 * exp_len);
        end
        crc_len = !f.fdf ? 15 : (exp_len <= 16 ? 21 : 25);
        push_rand(S_CRC, crc_len);
        push_one(S_CRCL, f.crc_lim, 0);
        if (!f.crc_lim) begin term = T_FERR; return; end
        push_one(S_ACK, 1'b0, 0);
        push_one(S_ACKL, f.ack_lim, 0);
        if (!f.ack_lim) begin term = T_FERR; return; end
        for (int i = 0; i < EOF_BITS; i++) begin
            bit b;
            b = (i == f.eof_dom) ? 1'b0 : 1'b1;
            push_one(S_EOF, b, i);
            if (!b && i <= EOF_BITS - 2) begin term = T_FERR; return; end
            if (i == EOF_BITS - 2) ok_idx = q_bit.size() - 1;
        end
        for (int i = 0; i < INTER_BITS; i++) begin
            bit b;
            b = (i == f.inter_dom) ? 1'b0 : 1'b1;
            push_one(S_INTER, b, i);
            if (!b) begin term = (i == INTER_BITS - 1) ? T_SOF : T_OVL; return; end
        end
        term = T_IDLE;
    endtask

    function automatic frame_t good_frame(bit ext, bit [28:0] id, bit fdf, bit [3:0] dlc);
        frame_t f;
        f.ext = ext; f.id = id; f.rtr = 1'b0; f.fdf = fdf; f.brs = 1'b0; f.esi = 1'b0;
        f.dlc = dlc; f.crc_lim = 1'b1; f.ack_lim = 1'b1; f.eof_dom = -1; f.inter_dom = -1;
        f.fd_en = 1'b1; f.max_bytes = 64;
        return f;
    endfunction

    // Drive one frame bit by bit, comparing state, counter and pulses after
    // every strobe and during idle gaps; abort_dbit >= 0 aborts at that DATA bit.
    task automatic run_frame(input frame_t f, input int abort_dbit, input string name);
        int abort_at;
        fd_enable = f.fd_en;
        build(f);
        sof_pending = 1'b0;
        abort_at = (abort_dbit >= 0 && data_start >= 0) ? data_start + abort_dbit : -1;
        for (int k = 0; k < q_bit.size(); k++) begin
            logic [4:0] es;
            logic [8:0] ec;
            logic [2:0] ep;
            rx_bit = q_bit[k];
            bit_valid = 1'b1;
            if (k == abort_at) begin
                abort = 1'b1;
                @(posedge clk); #1;
                bit_valid = 1'b0;
                abort = 1'b0;
                n_vec++;
                if ({o_st, o_cnt, o_pulse} !== {S_IDLE, 9'd0, 3'b000}) begin
                    n_err++;
                    $display("FAIL %s abort: got state=%0d cnt=%0d pulses=%b, want state=0 cnt=0 pulses=000",
                             name, o_st, o_cnt, o_pulse);
                end
                return;
            end
            @(posedge clk); #1;
            bit_valid = 1'b0;
            if (k + 1 < q_bit.size()) begin
                es = q_st[k+1];
                ec = 9'(q_cnt[k+1]);
            end else begin
                es = (term == T_SOF) ? S_ID1 : S_IDLE;
                ec = 9'd0;
            end
            ep = {k == ok_idx,
                  (k == q_bit.size() - 1) && term == T_FERR,
                  (k == q_bit.size() - 1) && term == T_OVL};
            n_vec++;
            if ({o_st, o_cnt, o_pulse} !== {es, ec, ep}) begin
                n_err++;
                $display("FAIL %s bit %0d: got state=%0d cnt=%0d ok/ferr/ovl=%b, want state=%0d cnt=%0d ok/ferr/ovl=%b",
                         name, k, o_st, o_cnt, o_pulse, es, ec, ep);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                n_vec++;
                if ({o_st, o_cnt, o_pulse} !== {es, ec, 3'b000}) begin
                    n_err++;
                    $display("FAIL %s hold after bit %0d: got state=%0d cnt=%0d pulses=%b, want state=%0d cnt=%0d pulses=000",
                             name, k, o_st, o_cnt, o_pulse, es, ec);
                end
            end
        end
        sof_pending = (term == T_SOF);
        if (term == T_SOF) begin
            n_vec++;
            if ({o_flags, o_dlc, o_len} !== 16'd0) begin
                n_err++;
                $display("FAIL %s sof-clear: got flags=%b dlc=%0d len=%0d, want all 0",
                         name, o_flags, o_dlc, o_len);
            end
        end else if (hdr_done) begin
            logic [28:0] mask;
            logic [4:0]  ef;
            mask = f.ext ? 29'h1FFF_FFFF : 29'h1FFC_0000;
            ef = {f.ext, f.fdf ? 1'b0 : f.rtr, f.fdf, f.fdf & f.brs, f.fdf & f.esi};
            n_vec++;
            if ({o_id & mask, o_flags, o_dlc, o_len} !== {f.id & mask, ef, f.dlc, 7'(exp_len)}) begin
                n_err++;
                $display("FAIL %s header: got id=%h flags=%b dlc=%0d len=%0d, want id=%h flags=%b dlc=%0d len=%0d",
                         name, o_id & mask, o_flags, o_dlc, o_len, f.id & mask, ef, f.dlc, exp_len);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        n_vec++;
        if ({st_a, cnt_a, id_a, ide_a, rtr_a, fdf_a, brs_a, esi_a, dlc_a, len_a, ok_a, fe_a, ov_a,
             st_b, cnt_b, id_b, ide_b, rtr_b, fdf_b, brs_b, esi_b, dlc_b, len_b, ok_b, fe_b, ov_b} !== '0) begin
            n_err++;
            $display("FAIL %s: got state=%0d/%0d cnt=%0d/%0d id=%h/%h dlc=%0d/%0d len=%0d/%0d, want all 0",
                     name, st_a, st_b, cnt_a, cnt_b, id_a, id_b, dlc_a, dlc_b, len_a, len_b);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset_asserted");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_released");
    endtask

    task automatic test_reset_midframe();
        // SOF plus a few ID bits, then reset together with abort.
        for (int i = 0; i < 6; i++) begin
            rx_bit = (i == 0) ? 1'b0 : 1'b1;
            bit_valid = 1'b1;
            @(posedge clk); #1;
        end
        bit_valid = 1'b1;
        abort = 1'b1;
        rst_n = 1'b0;
        #2 check_all_zero("reset_midframe");
        @(negedge clk);
        bit_valid = 1'b0; abort = 1'b0; rx_bit = 1'b1; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_classic_base();
        run_frame(good_frame(1'b0, 29'h123 << 18, 1'b0, 4'd2), -1, "classic_base");
    endtask

    task automatic test_fd_extended();
        frame_t f;
        f = good_frame(1'b1, 29'h1ABC_DEF0, 1'b1, 4'd15);
        f.brs = 1'b1;
        run_frame(f, -1, "fd_ext_64");
    endtask

    task automatic test_fd_disabled();
        frame_t f;
        f = good_frame(1'b0, 29'h2A5 << 18, 1'b1, 4'd3);
        f.fd_en = 1'b0;
        run_frame(f, -1, "fd_disabled");
    endtask

    task automatic test_crc_lim_error();
        frame_t f;
        f = good_frame(1'b0, 29'h7FF << 18, 1'b0, 4'd0);
        f.crc_lim = 1'b0;
        run_frame(f, -1, "crc_lim_dom");
        run_frame(good_frame(1'b0, 29'h055 << 18, 1'b0, 4'd1), -1, "after_crc_err");
    endtask

    task automatic test_ack_lim_error();
        frame_t f;
        f = good_frame(1'b1, 29'h0F0F_0F0F, 1'b0, 4'd4);
        f.ack_lim = 1'b0;
        run_frame(f, -1, "ack_lim_dom");
    endtask

    task automatic test_abort();
        run_frame(good_frame(1'b0, 29'h3C3 << 18, 1'b0, 4'd8), 20, "abort_data20");
        run_frame(good_frame(1'b1, 29'h1234_5678, 1'b0, 4'd5), -1, "after_abort");
    endtask

    task automatic test_max_bytes();
        frame_t f;
        sel = 1'b1;
        f = good_frame(1'b0, 29'h111 << 18, 1'b1, 4'd9);
        f.max_bytes = 8;
        run_frame(f, -1, "max8_fd_dlc9");
        f = good_frame(1'b1, 29'h0ABC_1234, 1'b0, 4'd12);
        f.max_bytes = 8;
        run_frame(f, -1, "max8_classic_dlc12");
        f = good_frame(1'b0, 29'h222 << 18, 1'b1, 4'd8);
        f.max_bytes = 8;
        run_frame(f, -1, "max8_fd_dlc8");
        sel = 1'b0;
    endtask

    task automatic test_eof_and_inter();
        frame_t f;
        f = good_frame(1'b0, 29'h321 << 18, 1'b0, 4'd1);
        f.eof_dom = $urandom_range(0, EOF_BITS - 2);
        run_frame(f, -1, "eof_dom_early");
        f.eof_dom = EOF_BITS - 1;
        run_frame(f, -1, "eof_dom_last");
        f.eof_dom = -1;
        f.inter_dom = 0;
        run_frame(f, -1, "inter_overload");
        f.inter_dom = INTER_BITS - 1;
        run_frame(f, -1, "inter_sof");
        f = good_frame(1'b1, 29'h1555_AAAA, 1'b1, 4'd10);
        f.esi = 1'b1;
        run_frame(f, -1, "after_inter_sof");
    endtask

    task automatic test_classic_rtr();
        frame_t f;
        f = good_frame(1'b0, 29'h404 << 18, 1'b0, 4'd6);
        f.rtr = 1'b1;
        run_frame(f, -1, "classic_rtr");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            frame_t f;
            f = good_frame(bit'(i[0]), 29'($urandom), bit'(i[1]), 4'($urandom_range(0, 15)));
            f.inter_dom = (i < 3) ? INTER_BITS - 1 : -1;
            run_frame(f, -1, "back_to_back");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            frame_t f;
            f = good_frame(rbit(), 29'($urandom), rbit(), 4'($urandom_range(0, 15)));
            f.rtr = rbit(); f.brs = rbit(); f.esi = rbit();
            run_frame(f, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_reset_midframe();
        test_classic_base();
        test_fd_extended();
        test_fd_disabled();
        test_crc_lim_error();
        test_ack_lim_error();
        test_abort();
        test_max_bytes();
        test_eof_and_inter();
        test_classic_rtr();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
